// File: rtl/row_packer_pkg.sv
// Shared privacy-pipeline word/line geometry used by the row packer.
package row_packer_pkg;

  localparam int unsigned WORD_BITS      = 32;
  localparam int unsigned LINE_BITS      = 512;
  localparam int unsigned WORDS_PER_LINE = 16;

endpackage

// File: rtl/row_packer.sv
// Packs rows of COL_COUNT 32-bit fields densely into 512-bit lines; the last
// line of each stream is padded with PAD_WORD and flagged with output_last.
module row_packer
  import row_packer_pkg::*;
#(
  parameter int unsigned COL_COUNT = 3,
  parameter logic [31:0] PAD_WORD  = 32'h0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [COL_COUNT*WORD_BITS-1:0] input_data,
  input  logic                           input_valid,
  input  logic                           input_last,
  output logic                           input_ready,
  output logic [LINE_BITS-1:0]           output_data,
  output logic                           output_valid,
  output logic                           output_last,
  input  logic                           output_ready
);

  localparam int unsigned ACC_WORDS = WORDS_PER_LINE + COL_COUNT - 1;
  localparam int unsigned FILL_W    = $clog2(WORDS_PER_LINE + COL_COUNT);

  typedef enum logic {ACCUM, FLUSH} state_t;
  typedef logic [ACC_WORDS-1:0][WORD_BITS-1:0] acc_t;

  state_t               state, state_d;
  acc_t                 acc, acc_d, merged;
  logic [FILL_W-1:0]    fill, fill_d, nf;
  logic [LINE_BITS-1:0] data_d;
  logic                 valid_d, last_d;
  logic                 out_free, accept;

  // First n slots of src, remaining lanes padded.
  function automatic logic [LINE_BITS-1:0] pad_line(input acc_t src, input logic [FILL_W-1:0] n);
    logic [LINE_BITS-1:0] line;
    line = '0;
    for (int unsigned i = 0; i < WORDS_PER_LINE; i++)
      line[i*WORD_BITS +: WORD_BITS] = (i < 32'(n)) ? src[i] : PAD_WORD;
    return line;
  endfunction

  assign out_free    = !output_valid || output_ready;
  assign input_ready = (state == ACCUM) && out_free && !rst;
  assign accept      = input_valid && input_ready;
  assign nf          = fill + FILL_W'(COL_COUNT);

  always_comb begin
    merged = acc;
    for (int unsigned i = 0; i < ACC_WORDS; i++)
      if (i >= 32'(fill) && i < 32'(fill) + COL_COUNT)
        merged[i] = input_data[(i - 32'(fill))*WORD_BITS +: WORD_BITS];
  end

  always_comb begin
    state_d = state;
    fill_d  = fill;
    acc_d   = acc;
    data_d  = output_data;
    valid_d = output_valid && !output_ready;
    last_d  = output_last;
    unique case (state)
      ACCUM: begin
        if (accept) begin
          if (nf < FILL_W'(WORDS_PER_LINE)) begin
            acc_d = merged;
            if (input_last) begin
              data_d  = pad_line(merged, nf);
              valid_d = 1'b1;
              last_d  = 1'b1;
              fill_d  = '0;
            end else begin
              fill_d = nf;
            end
          end else begin
            data_d  = pad_line(merged, FILL_W'(WORDS_PER_LINE));
            valid_d = 1'b1;
            // Words past the line boundary slide down to slot 0.
            for (int unsigned i = 0; i < ACC_WORDS - WORDS_PER_LINE; i++)
              acc_d[i] = merged[i + WORDS_PER_LINE];
            fill_d = nf - FILL_W'(WORDS_PER_LINE);
            last_d = input_last && (nf == FILL_W'(WORDS_PER_LINE));
            if (input_last && (nf != FILL_W'(WORDS_PER_LINE)))
              state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          data_d  = pad_line(acc, fill);
          valid_d = 1'b1;
          last_d  = 1'b1;
          fill_d  = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACCUM;
      fill         <= '0;
      acc          <= '0;
      output_data  <= '0;
      output_valid <= 1'b0;
      output_last  <= 1'b0;
    end else begin
      state        <= state_d;
      fill         <= fill_d;
      acc          <= acc_d;
      output_data  <= data_d;
      output_valid <= valid_d;
      output_last  <= last_d;
    end
  end

endmodule
